// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: sequencer state encoding,
// requester identifiers and default bus widths.
package mem_arb_pkg;

    // Default memory geometry: 64 words of 32 bits.
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    // Access sequencer states; one transaction walks IDLE->ISSUE->CAPT->ACK.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] CAPT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    // Requester identifiers, also the encoding of gnt_id.
    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA  = 2'd1;
    localparam logic [1:0] REQ_DBG   = 2'd2;

    // Number of requesters sharing the port.
    localparam int NUM_REQ = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory port arbiter.
// Debug is ranked by DBG_FIRST (top, or just below data). Between fetch and
// data the order is fixed (data first) unless MEM_ARB_RR_EN is defined, in
// which case the one granted most recently loses a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit DBG_FIRST = 1'b1
) (
    input  logic       f_req,
    input  logic       d_req,
    input  logic       g_req,
    input  logic       rr_last_data,
    output logic       valid,
    output logic [1:0] id
);

    logic [1:0] fd_id;

`ifndef MEM_ARB_RR_EN
    // The pointer only matters for round-robin; keep it visibly consumed.
    logic unused_rr;
    assign unused_rr = rr_last_data;
`endif

    // Resolve fetch versus data on their own.
    always_comb begin
        fd_id = REQ_FETCH;
`ifdef MEM_ARB_RR_EN
        if (f_req && d_req) begin
            fd_id = rr_last_data ? REQ_FETCH : REQ_DATA;
        end else if (d_req) begin
            fd_id = REQ_DATA;
        end
`else
        if (d_req) begin
            fd_id = REQ_DATA;
        end
`endif
    end

    // Slot debug into the order according to its rank.
    always_comb begin
        valid = f_req | d_req | g_req;
        id    = fd_id;
        if (DBG_FIRST) begin
            if (g_req) begin
                id = REQ_DBG;
            end
        end else begin
            if (g_req && !d_req) begin
                id = REQ_DBG;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter in front of a single-port synchronous memory with one
// cycle of read latency. A four-state sequencer captures the winning request
// in IDLE, drives the memory in ISSUE, loads read data at the end of CAPT and
// pulses the winner's ack during ACK.
// Optional feature macro: MEM_ARB_RR_EN (round-robin between fetch and data).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit DBG_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt_id,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]         state_reg;
    logic [1:0]         state_next;

    logic               pick_valid;
    logic [1:0]         pick_id;
    logic               rr_last_data;
    logic               grant;

    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    logic [1:0]         gnt_id_reg;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [DATA_W-1:0]  rdata_reg;

    logic [NUM_REQ-1:0] ack_next;
    logic [NUM_REQ-1:0] ack_reg;

    mem_arb_pick #(
        .DBG_FIRST    (DBG_FIRST)
    ) u_pick (
        .f_req        (f_req),
        .d_req        (d_req),
        .g_req        (g_req),
        .rr_last_data (rr_last_data),
        .valid        (pick_valid),
        .id           (pick_id)
    );

    // A request is only ever committed from IDLE.
    assign grant = (state_reg == IDLE) && pick_valid;

    // Sequencer state register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sequencer next state: wait in IDLE for a request, then a fixed walk.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   state_next = CAPT;
            CAPT:    state_next = ACK;
            default: state_next = IDLE;
        endcase
    end

    // Sequencer outputs: the memory is only touched during ISSUE.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_reg == ISSUE) begin
            mem_en    = 1'b1;
            mem_we    = we_reg;
            mem_addr  = addr_reg;
            mem_wdata = wdata_reg;
        end
    end

    // Route the winner's fields towards the capture registers; fetch is read-only.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = f_addr;
        sel_wdata = '0;
        case (pick_id)
            REQ_DATA: begin
                sel_we    = d_we;
                sel_addr  = d_addr;
                sel_wdata = d_wdata;
            end
            REQ_DBG: begin
                sel_we    = g_we;
                sel_addr  = g_addr;
                sel_wdata = g_wdata;
            end
            default: begin
                sel_we    = 1'b0;
                sel_addr  = f_addr;
                sel_wdata = '0;
            end
        endcase
    end

    // Capture the committed request; later changes on the request side are ignored.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            gnt_id_reg <= REQ_FETCH;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else if (grant) begin
            gnt_id_reg <= pick_id;
            we_reg     <= sel_we;
            addr_reg   <= sel_addr;
            wdata_reg  <= sel_wdata;
        end
    end

    // Load read data at the end of CAPT; writes leave the last read value alone.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rdata_reg <= '0;
        end else if ((state_reg == CAPT) && !we_reg) begin
            rdata_reg <= mem_rdata;
        end
    end

    // One ack line per requester, armed on the cycle leading into ACK.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack_sel
            assign ack_next[gi] = (state_reg == CAPT) && (gnt_id_reg == 2'(gi));
        end
    endgenerate

    // Registered acks, high only during ACK.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            ack_reg <= '0;
        end else begin
            ack_reg <= ack_next;
        end
    end

`ifdef MEM_ARB_RR_EN
    logic rr_last_data_reg;

    // Remember whether data or fetch won last; starts as "data last" so fetch wins the first tie.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rr_last_data_reg <= 1'b1;
        end else if (grant && (pick_id != REQ_DBG)) begin
            rr_last_data_reg <= (pick_id == REQ_DATA);
        end
    end

    assign rr_last_data = rr_last_data_reg;
`else
    assign rr_last_data = 1'b1;
`endif

    assign f_ack  = ack_reg[REQ_FETCH];
    assign d_ack  = ack_reg[REQ_DATA];
    assign g_ack  = ack_reg[REQ_DBG];
    assign rdata  = rdata_reg;
    assign gnt_id = gnt_id_reg;
    assign busy   = (state_reg != IDLE);

endmodule
